// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
// Holds the M-extension opcode fields, FSM state encoding and register-address type.
package ex_muldiv_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int unsigned REG_ADDR_W = 5;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam logic [6:0] INST_FUNCT7_M = 7'b0000001;

    localparam logic [2:0] INST_FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] INST_FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] INST_FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] INST_FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] INST_FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] INST_FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] INST_FUNCT3_REM    = 3'b110;
    localparam logic [2:0] INST_FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        EX_MD_IDLE = 2'd0,
        EX_MD_CALC = 2'd1,
        EX_MD_DONE = 2'd2
    } ex_md_state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned one-bit-per-cycle datapath: shift-add multiply and restoring divide.
// The accumulator's high half is the partial product / remainder, the low half the multiplier / quotient.
module muldiv_iter_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   mag1,
    input  logic [XLEN-1:0]   mag2,
    output logic [2*XLEN-1:0] product,
    output logic [XLEN-1:0]   quotient,
    output logic [XLEN-1:0]   remainder
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q;
    logic [XLEN-1:0]   mul_addend;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     trial;

    always_comb begin
        mul_addend = acc_q[0] ? opb_q : '0;
        add_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
        // Shifted-in remainder minus divisor; MSB set means the subtraction must be undone.
        trial      = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opb_q};
        acc_d      = acc_q;
        if (is_div) begin
            if (!trial[XLEN]) begin
                acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            end
        end else begin
            acc_d = {add_sum, acc_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            opb_q <= '0;
        end else if (load) begin
            acc_q <= {{XLEN{1'b0}}, mag1};
            opb_q <= mag2;
        end else if (step) begin
            acc_q <= acc_d;
        end
    end

    assign product   = acc_q;
    assign quotient  = acc_q[XLEN-1:0];
    assign remainder = acc_q[2*XLEN-1:XLEN];

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: pauses the pipeline for XLEN cycles,
// then issues one write-back with an unpause pulse. Flush aborts silently.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_signal,
    input  logic            req_valid,
    input  logic [2:0]      req_funct3,
    input  logic [4:0]      req_rd,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            busy,
    output logic            pause_signal,
    output logic            unpause_signal,
    output logic            regs_write_en,
    output logic [4:0]      regs_write_addr,
    output logic [XLEN-1:0] regs_write_data
);

    localparam int unsigned     CNT_W   = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    ex_md_state_e     state_q, state_d;
    logic [2:0]       funct3_q;
    reg_addr_t        rd_q;
    logic             sign1_q, sign2_q, div0_q, ovf_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept, op_signed1, op_signed2, sign1, sign2, req_div0, req_ovf;
    logic [XLEN-1:0]  mag1, mag2;
    logic [2*XLEN-1:0] product, prod_fix;
    logic [XLEN-1:0]  quotient, remainder, quo_res, rem_res, result;

    assign accept     = (state_q == EX_MD_IDLE) && req_valid && !flush_signal;
    assign op_signed1 = (req_funct3 != INST_FUNCT3_MULHU) && (req_funct3 != INST_FUNCT3_DIVU) &&
                        (req_funct3 != INST_FUNCT3_REMU);
    assign op_signed2 = op_signed1 && (req_funct3 != INST_FUNCT3_MULHSU);
    assign sign1      = op_signed1 && operand1[XLEN-1];
    assign sign2      = op_signed2 && operand2[XLEN-1];
    assign mag1       = sign1 ? -operand1 : operand1;
    assign mag2       = sign2 ? -operand2 : operand2;
    assign req_div0   = req_funct3[2] && (operand2 == '0);
    assign req_ovf    = req_funct3[2] && !req_funct3[0] && (operand1 == MIN_INT) &&
                        (operand2 == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EX_MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EX_MD_IDLE: begin
                if (accept) begin
                    state_d = (req_div0 || req_ovf) ? EX_MD_DONE : EX_MD_CALC;
                end
            end
            EX_MD_CALC: begin
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = EX_MD_DONE;
                end
            end
            EX_MD_DONE: state_d = EX_MD_IDLE;
            default:    state_d = EX_MD_IDLE;
        endcase
        if (flush_signal) begin
            state_d = EX_MD_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q <= '0;
            rd_q     <= '0;
            sign1_q  <= FALSE;
            sign2_q  <= FALSE;
            div0_q   <= FALSE;
            ovf_q    <= FALSE;
            cnt_q    <= '0;
        end else if (accept) begin
            funct3_q <= req_funct3;
            rd_q     <= req_rd;
            sign1_q  <= sign1;
            sign2_q  <= sign2;
            div0_q   <= req_div0;
            ovf_q    <= req_ovf;
            cnt_q    <= '0;
        end else if (state_q == EX_MD_CALC) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    muldiv_iter_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (state_q == EX_MD_CALC),
        .is_div    (funct3_q[2]),
        .mag1      (mag1),
        .mag2      (mag2),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_comb begin
        prod_fix = (sign1_q ^ sign2_q) ? -product : product;
        quo_res  = (sign1_q ^ sign2_q) ? -quotient : quotient;
        rem_res  = sign1_q ? -remainder : remainder;
        // No iterations ran on divide-by-zero, so the low half still holds |operand1|.
        if (div0_q) begin
            quo_res = '1;
            rem_res = sign1_q ? -quotient : quotient;
        end else if (ovf_q) begin
            quo_res = MIN_INT;
            rem_res = '0;
        end
        case (funct3_q)
            INST_FUNCT3_MUL:                      result = prod_fix[XLEN-1:0];
            INST_FUNCT3_DIV, INST_FUNCT3_DIVU:    result = quo_res;
            INST_FUNCT3_REM, INST_FUNCT3_REMU:    result = rem_res;
            default:                              result = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        busy            = (state_q != EX_MD_IDLE);
        pause_signal    = (state_q == EX_MD_CALC);
        unpause_signal  = (state_q == EX_MD_DONE) && !flush_signal;
        regs_write_en   = unpause_signal && (rd_q != '0);
        regs_write_addr = rd_q;
        regs_write_data = (state_q == EX_MD_DONE) ? result : '0;
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed plan cases plus randomized ops
// checked against a plain-arithmetic RV32M reference model.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_signal;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic [31:0] operand1, operand2;
    logic        busy, pause_signal, unpause_signal, regs_write_en;
    logic [4:0]  regs_write_addr;
    logic [31:0] regs_write_data;

    int tests = 0;
    int fails = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_signal    (flush_signal),
        .req_valid       (req_valid),
        .req_funct3      (req_funct3),
        .req_rd          (req_rd),
        .operand1        (operand1),
        .operand2        (operand2),
        .busy            (busy),
        .pause_signal    (pause_signal),
        .unpause_signal  (unpause_signal),
        .regs_write_en   (regs_write_en),
        .regs_write_addr (regs_write_addr),
        .regs_write_data (regs_write_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, q;
        logic [63:0] p, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa / sb;
                return q[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = sa % sb;
                return q[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (f3 < 3'd4) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return (f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; the request is accepted at the following posedge (cycle 0).
    task automatic run_op(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input bit poke, input string tag);
        logic [31:0] exp_data;
        int          exp_lat, c, pause_cnt, early_we;
        logic [31:0] got_data;
        logic        got_we;
        logic [4:0]  got_addr;
        exp_data   = ref_model(f3, a, b);
        exp_lat    = is_special(f3, a, b) ? 1 : 33;
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rd     = rd;
        operand1   = a;
        operand2   = b;
        @(negedge clk);
        req_valid  = poke;
        req_funct3 = 3'($urandom);
        req_rd     = 5'($urandom);
        operand1   = $urandom;
        operand2   = $urandom;
        c = 1;
        pause_cnt = 0;
        early_we = 0;
        while (c <= 40 && unpause_signal !== 1'b1) begin
            if (pause_signal === 1'b1) pause_cnt++;
            if (regs_write_en === 1'b1) early_we++;
            @(negedge clk);
            c++;
        end
        got_data = regs_write_data;
        got_we   = regs_write_en;
        got_addr = regs_write_addr;
        check({tag, ".latency"}, 64'(c), 64'(exp_lat));
        check({tag, ".data"}, 64'(got_data), 64'(exp_data));
        check({tag, ".we"}, 64'(got_we), 64'(rd != 5'd0));
        check({tag, ".addr"}, 64'(got_addr), 64'(rd));
        check({tag, ".pause_cycles"}, 64'(pause_cnt), 64'(exp_lat - 1));
        check({tag, ".early_we"}, 64'(early_we), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, ".idle_after"}, 64'({busy, unpause_signal, regs_write_en}), 64'd0);
    endtask

    initial begin
        int seen;
        rst          = 1'b1;
        flush_signal = 1'b0;
        req_valid    = 1'b0;
        req_funct3   = 3'd0;
        req_rd       = 5'd0;
        operand1     = 32'd0;
        operand2     = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset.outputs", 64'({busy, pause_signal, unpause_signal, regs_write_en,
                                    regs_write_addr, regs_write_data}), 64'd0);

        run_op(3'd0, 5'd3, 32'd7, 32'hFFFF_FFFD, 1'b0, "mul_7_m3");
        run_op(3'd1, 5'd4, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulh_min_min");
        run_op(3'd3, 5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhu_ones");
        run_op(3'd2, 5'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu_ones");
        run_op(3'd4, 5'd7, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        run_op(3'd6, 5'd8, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem_m7_2");
        run_op(3'd5, 5'd9, 32'd7, 32'd2, 1'b0, "divu_7_2");
        run_op(3'd7, 5'd10, 32'hFFFF_FFFF, 32'd16, 1'b0, "remu_ff_16");
        run_op(3'd4, 5'd11, 32'd5, 32'd0, 1'b0, "div_by_zero");
        run_op(3'd6, 5'd12, 32'd5, 32'd0, 1'b0, "rem_by_zero");
        run_op(3'd4, 5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
        run_op(3'd6, 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_overflow");

        // Flush in cycle 10 of a DIVU, then a fresh MUL in cycle 11.
        req_valid  = 1'b1;
        req_funct3 = 3'd5;
        req_rd     = 5'd15;
        operand1   = 32'd1000;
        operand2   = 32'd7;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 0;
        for (int c = 1; c < 10; c++) begin
            if (unpause_signal === 1'b1 || regs_write_en === 1'b1) seen++;
            @(negedge clk);
        end
        flush_signal = 1'b1;
        if (unpause_signal === 1'b1 || regs_write_en === 1'b1) seen++;
        @(negedge clk);
        check("flush.busy_next", 64'(busy), 64'd0);
        flush_signal = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (unpause_signal === 1'b1 || regs_write_en === 1'b1) seen++;
            if (c == 0) begin
                run_op(3'd0, 5'd16, 32'd3, 32'd4, 1'b0, "mul_after_flush");
            end
        end
        check("flush.no_writeback", 64'(seen), 64'd0);

        // Flush beats a simultaneous request in IDLE.
        flush_signal = 1'b1;
        req_valid    = 1'b1;
        req_funct3   = 3'd0;
        req_rd       = 5'd2;
        @(negedge clk);
        check("flush.blocks_req", 64'(busy), 64'd0);
        flush_signal = 1'b0;
        req_valid    = 1'b0;

        run_op(3'd0, 5'd17, 32'd123, 32'd456, 1'b1, "mul_poked_busy");
        run_op(3'd0, 5'd0, 32'd9, 32'd9, 1'b0, "mul_rd0");

        // Reset mid-CALC.
        req_valid  = 1'b1;
        req_funct3 = 3'd1;
        req_rd     = 5'd21;
        operand1   = 32'h1234_5678;
        operand2   = 32'h9ABC_DEF0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rst.mid_busy", 64'({busy, pause_signal}), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        check("rst.mid_outputs", 64'({busy, pause_signal, unpause_signal, regs_write_en,
                                      regs_write_addr, regs_write_data}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), 5'($urandom), pick(), pick(), bit'($urandom_range(0, 1)),
                   $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative RV32M multiply/divide execution unit that sits beside the combinational execute stage. It accepts one OP-type instruction with funct7=0000001 and latches its operands. It computes the result over XLEN iterations while holding the pipeline paused. It then issues a single register write-back together with a one-cycle unpause pulse. The pipeline flush input aborts any operation in flight.

Parameters:
XLEN, 32, operand/result width in bits; must be a power of two and at least 8
CNT_W, $clog2(XLEN)+1, iteration counter width (localparam, derived)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush_signal  input  1  pipeline flush; aborts the current operation
req_valid  input  1  start request for an M-extension instruction
req_funct3  input  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
req_rd  input  5  destination register address
operand1  input  XLEN  rs1 value
operand2  input  XLEN  rs2 value
busy  output  1  high whenever the state is not IDLE
pause_signal  output  1  high in CALC; stalls the upstream pipeline
unpause_signal  output  1  one-cycle pulse in DONE
regs_write_en  output  1  write-back strobe, DONE only
regs_write_addr  output  5  latched rd
regs_write_data  output  XLEN  final result

Behaviour:
- Reset and flush: clk and rst only; reset is synchronous and active-high. After reset, state=IDLE and every output is 0, including regs_write_data and regs_write_addr.
- FSM states: IDLE, CALC, DONE.
- IDLE: when req_valid=1 and flush_signal=0, latch funct3, rd, the operand signs and the operand magnitudes, and clear the counter.
  - Normal case: next state is CALC.
  - Special case: next state is DONE directly when divisor=0 (DIV/DIVU/REM/REMU), or for signed overflow (DIV/REM with operand1=MIN_INT, operand2=-1).
- CALC: one iteration per cycle; the counter counts 0..XLEN-1. After the XLEN-th iteration the next state is DONE.
  - Multiply: shift-add on magnitudes, producing a 2*XLEN-bit unsigned product.
  - Divide: restoring shift-subtract, producing an XLEN-bit quotient and remainder.
- DONE: regs_write_en=1 and unpause_signal=1 for exactly one cycle, then the state returns to IDLE. A req_valid in DONE is ignored.
- Latency: with the accept edge as cycle 0, the normal result is visible in cycle XLEN+1 (cycle 33 for XLEN=32). Special cases are visible in cycle 1.
- Signedness:
  - MUL, MULH, DIV and REM treat both operands as signed.
  - MULHSU treats operand1 as signed and operand2 as unsigned.
  - MULHU, DIVU and REMU treat both operands as unsigned.
  - Negative signed operands are converted to magnitudes at accept.
- Sign fix-up in DONE:
  - Product is negated when sign1^sign2.
  - Quotient is negated when sign1^sign2.
  - Remainder takes the sign of the dividend.
- Result select: MUL takes product[XLEN-1:0]; the MULH* ops take product[2XLEN-1:XLEN]; DIV* returns the quotient; REM* returns the remainder.
- Divide-by-zero: quotient = all ones; remainder = operand1 unchanged.
- Signed overflow: quotient = MIN_INT; remainder = 0.
- rd=0: the full operation still runs and unpause_signal still pulses. regs_write_en stays 0 and regs_write_addr=0.
- Requests while busy: req_valid is ignored whenever busy=1. No queueing; upstream holds the instruction until unpause.
- Flush:
  - flush_signal=1 in any state forces IDLE at the next edge.
  - The aborted operation produces no write-back and no unpause pulse.
  - Flush takes priority over a simultaneous req_valid and over DONE outputs; in DONE, regs_write_en and unpause_signal are gated to 0 combinationally.
- Reset mid-operation behaves like flush and also clears all datapath registers.
- Outputs are registered or decoded from the state only; there are no combinational paths from operand1 or operand2 to any output.

Decomposition:
- Shared define file:
  - M-extension funct7 constant INST_FUNCT7_M=7'b0000001.
  - INST_FUNCT3_MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
  - State encodings EX_MD_IDLE/CALC/DONE.
  - Existing `true/`false and REG_ADDR.
- One sub-module, muldiv_iter_core (parameter XLEN):
  - Holds the unsigned shift-add/shift-subtract datapath, with inputs load, step, is_div and the magnitudes.
  - Outputs a 2XLEN product, quotient and remainder.
- ex_muldiv keeps the FSM, counter, sign handling, special cases and write-back.

Test Plan:
1. MUL: operand1=7, operand2=0xFFFFFFFD. Expected 0xFFFFFFEB, with regs_write_en and unpause high only in cycle 33 and pause_signal high in cycles 1-32.
2. High multiplies:
   - MULH 0x80000000 x 0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. Divides:
   - DIV -7/2 -> 0xFFFFFFFD.
   - REM -7/2 -> 0xFFFFFFFF.
   - DIVU 7/2 -> 3.
   - REMU 0xFFFFFFFF/16 -> 15.
4. Special cases, each with write-back in cycle 1:
   - DIV 5/0 -> 0xFFFFFFFF.
   - REM 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
   - REM of the same operands -> 0.
5. Flush: flush_signal=1 in cycle 10 of a DIVU. Expect busy=0 in cycle 11, no regs_write_en or unpause ever. A new MUL 3x4 started in cycle 11 returns 12.
6. Ignored and suppressed requests:
   - A second req_valid while busy leaves the first result unchanged.
   - rd=0 MUL gives regs_write_en=0, unpause pulse=1.
   - rst asserted mid-CALC gives all outputs 0 on the next cycle.
